mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares the single read/write port of a block RAM (DMEM port A or IMEM port A) between the CPU X-stage access and an external DMA/program-loader requester.
- CPU has priority. A starvation counter forces a DMA grant after MAX_WAIT contended cycles, and the CPU pipeline is stalled for that cycle.
- Tracks ownership of the 1-cycle-latency read data and steers the read-valid strobe back to the requester that issued the read.

Parameters:
- AW, 12, word-address width of the RAM port.
- MAX_WAIT, 4, contended cycles a waiting DMA request tolerates before a forced grant; legal range 1..255.

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- cpu_req  in  1  CPU access this cycle (load or store)
- cpu_we  in  4  CPU byte write enables (big-endian, bit3 = byte0); 0 means read
- cpu_addr  in  AW  CPU word address
- cpu_wdata  in  32  CPU store data
- cpu_stall  out  1  CPU must hold its X stage this cycle
- cpu_rvalid  out  1  mem_rdata belongs to a CPU read issued last cycle
- dma_valid  in  1  DMA request pending
- dma_ready  out  1  DMA request accepted this cycle
- dma_we  in  4  DMA byte write enables; 0 means read
- dma_addr  in  AW  DMA word address
- dma_wdata  in  32  DMA write data
- dma_rvalid  out  1  mem_rdata belongs to a DMA read accepted last cycle
- mem_en  out  1  RAM port enable
- mem_we  out  4  RAM byte write enables
- mem_addr  out  AW  RAM address
- mem_din  out  32  RAM write data
- mem_dout  in  32  RAM read data, 1-cycle latency
- mem_rdata  out  32  mem_dout passed through to both requesters

Behaviour:
- Forced grant: force = (wait_cnt == MAX_WAIT).
- DMA grant: grant_dma = dma_valid & (~cpu_req | force).
- CPU grant: grant_cpu = cpu_req & ~grant_dma.
- cpu_stall = cpu_req & grant_dma.
- dma_ready = grant_dma.
- All of the above are combinational and forced to 0 while rst is high.
- Port mux: mem_en = grant_cpu | grant_dma. mem_we, mem_addr and mem_din come from the granted requester. With no grant: mem_we = 0, mem_addr = 0, mem_din = 0.
- wait_cnt (8 bit):
  - cleared when grant_dma or ~dma_valid;
  - incremented when dma_valid & cpu_req & ~grant_dma;
  - never exceeds MAX_WAIT.
- Read tracking FSM, states IDLE, RD_CPU, RD_DMA, registered each cycle:
  - next = RD_CPU if grant_cpu & (cpu_we == 0);
  - RD_DMA if grant_dma & (dma_we == 0);
  - else IDLE.
  - cpu_rvalid = (state == RD_CPU); dma_rvalid = (state == RD_DMA). Both are registered, so each pulses exactly 1 cycle after the accepting cycle.
  - Back-to-back reads pipeline: one read is accepted and one returned per cycle, with no bubble.
- Writes: no rvalid. Byte-enable semantics pass through unchanged.
- DMA handshake: dma_* inputs must hold stable while dma_valid & ~dma_ready. dma_valid may drop only after acceptance.
- Simultaneous requests:
  - CPU wins unless force is set.
  - On a forced grant the CPU is stalled exactly one cycle and re-granted next cycle if cpu_req is still high. wait_cnt is 0 at that point, so the CPU then wins again.
- Reset (asynchronous):
  - wait_cnt = 0, state = IDLE, cpu_rvalid = dma_rvalid = 0.
  - Combinational outputs are gated to 0: mem_en = 0, mem_we = 0, dma_ready = 0, cpu_stall = 0.
  - A read in flight when rst asserts is dropped: no rvalid after rst deasserts.
- Latency: DMA uncontended accept is 0 cycles (same cycle as dma_valid). Read data is returned 1 cycle after accept.

Decomposition:
- Shared package mem_arb_pkg: rd_state_t enum (IDLE, RD_CPU, RD_DMA), WE_NONE = 4'b0000, default AW.
- One natural sub-module, arb_starve_ctr: the wait_cnt counter with force output, parameterised by MAX_WAIT.
- Grant logic, port mux and read FSM stay in the top module.

Test Plan:
- Reset mid-read: DMA read accepted, rst pulsed next cycle → dma_rvalid never asserts; wait_cnt = 0; mem_en = 0 during rst.
- Uncontended DMA write: dma_valid = 1, dma_we = 4'b1111, addr = 0x010, wdata = 0xDEADBEEF → same cycle dma_ready = 1, mem_we = 4'b1111, mem_addr = 0x010, mem_din = 0xDEADBEEF; no rvalid next cycle.
- CPU priority: cpu_req = 1 (read, addr 0x004) and dma_valid = 1 both held → cpu granted cycles 0–3, cpu_stall = 0 in those cycles. Cycle 4 (MAX_WAIT = 4): dma_ready = 1, cpu_stall = 1. Cycle 5: CPU granted again and wait_cnt = 0.
- Read steering: cycle 0 CPU read 0x020, cycle 1 DMA read 0x030 (cpu_req = 0), RAM model returns 0x11111111 then 0x22222222 → cycle 1 cpu_rvalid = 1 with mem_rdata = 0x11111111; cycle 2 dma_rvalid = 1 with mem_rdata = 0x22222222.
- Byte store: CPU cpu_we = 4'b0010, addr 0x005, wdata = 0x0000AB00, no DMA → mem_we = 4'b0010, mem_en = 1, cpu_stall = 0, no rvalid.
- dma_valid dropping while waiting: cpu_req held, dma_valid high 2 cycles then low 1 cycle then high → wait_cnt resets to 0; forced grant occurs 4 contended cycles after re-assertion, not earlier.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the memory-port arbiter slice.
package mem_arb_pkg;

    localparam int unsigned DEFAULT_AW = 12;
    localparam logic [3:0]  WE_NONE    = 4'b0000;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RD_CPU = 2'd1,
        RD_DMA = 2'd2
    } rd_state_t;

endpackage

// File: rtl/arb_starve_ctr.sv
// Starvation counter: counts cycles a pending DMA request loses to the CPU and
// raises forceGrant once MAX_WAIT such cycles have elapsed.
module arb_starve_ctr #(
    parameter int unsigned MAX_WAIT = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       dmaValid,
    input  logic       cpuReq,
    input  logic       grantDma,
    output logic       forceGrant,
    output logic [7:0] waitCnt
);

    localparam logic [7:0] MAX_CNT = 8'(MAX_WAIT);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            waitCnt <= '0;
        end else if (grantDma || !dmaValid) begin
            waitCnt <= '0;
        end else if (cpuReq && (waitCnt != MAX_CNT)) begin
            waitCnt <= waitCnt + 8'd1;
        end
    end

    assign forceGrant = (waitCnt == MAX_CNT);

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one block-RAM port between the CPU X stage and a DMA/loader requester,
// CPU-priority with starvation-forced DMA grants and read-data ownership tracking.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned AW       = DEFAULT_AW,
    parameter int unsigned MAX_WAIT = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cpu_req,
    input  logic [3:0]    cpu_we,
    input  logic [AW-1:0] cpu_addr,
    input  logic [31:0]   cpu_wdata,
    output logic          cpu_stall,
    output logic          cpu_rvalid,
    input  logic          dma_valid,
    output logic          dma_ready,
    input  logic [3:0]    dma_we,
    input  logic [AW-1:0] dma_addr,
    input  logic [31:0]   dma_wdata,
    output logic          dma_rvalid,
    output logic          mem_en,
    output logic [3:0]    mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [31:0]   mem_din,
    input  logic [31:0]   mem_dout,
    output logic [31:0]   mem_rdata
);

    logic      grantCpu;
    logic      grantDma;
    logic      forceGrant;
    logic [7:0] waitCnt;
    rd_state_t rdState;
    rd_state_t rdNext;

    arb_starve_ctr #(
        .MAX_WAIT(MAX_WAIT)
    ) starveCtr (
        .clk       (clk),
        .rst       (rst),
        .dmaValid  (dma_valid),
        .cpuReq    (cpu_req),
        .grantDma  (grantDma),
        .forceGrant(forceGrant),
        .waitCnt   (waitCnt)
    );

    // Grants are gated by rst so the RAM port is idle for the whole reset pulse.
    assign grantDma  = !rst && dma_valid && (!cpu_req || forceGrant);
    assign grantCpu  = !rst && cpu_req && !grantDma;
    assign cpu_stall = cpu_req && grantDma;
    assign dma_ready = grantDma;
    assign mem_en    = grantCpu || grantDma;

    always_comb begin
        mem_we   = WE_NONE;
        mem_addr = '0;
        mem_din  = '0;
        if (grantCpu) begin
            mem_we   = cpu_we;
            mem_addr = cpu_addr;
            mem_din  = cpu_wdata;
        end else if (grantDma) begin
            mem_we   = dma_we;
            mem_addr = dma_addr;
            mem_din  = dma_wdata;
        end
    end

    always_comb begin
        rdNext = IDLE;
        if (grantCpu && (cpu_we == WE_NONE)) begin
            rdNext = RD_CPU;
        end else if (grantDma && (dma_we == WE_NONE)) begin
            rdNext = RD_DMA;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdState <= IDLE;
        end else begin
            rdState <= rdNext;
        end
    end

    assign cpu_rvalid = (rdState == RD_CPU);
    assign dma_rvalid = (rdState == RD_DMA);
    assign mem_rdata  = mem_dout;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed self-checking bench for mem_port_arbiter (AW=12, MAX_WAIT=4).
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        cpu_req;
    logic [3:0]  cpu_we;
    logic [11:0] cpu_addr;
    logic [31:0] cpu_wdata;
    logic        cpu_stall;
    logic        cpu_rvalid;
    logic        dma_valid;
    logic        dma_ready;
    logic [3:0]  dma_we;
    logic [11:0] dma_addr;
    logic [31:0] dma_wdata;
    logic        dma_rvalid;
    logic        mem_en;
    logic [3:0]  mem_we;
    logic [11:0] mem_addr;
    logic [31:0] mem_din;
    logic [31:0] mem_dout = '0;
    logic [31:0] mem_rdata;

    int unsigned passCnt  = 0;
    int unsigned totalCnt = 0;

    mem_port_arbiter #(
        .AW      (12),
        .MAX_WAIT(4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .cpu_req   (cpu_req),
        .cpu_we    (cpu_we),
        .cpu_addr  (cpu_addr),
        .cpu_wdata (cpu_wdata),
        .cpu_stall (cpu_stall),
        .cpu_rvalid(cpu_rvalid),
        .dma_valid (dma_valid),
        .dma_ready (dma_ready),
        .dma_we    (dma_we),
        .dma_addr  (dma_addr),
        .dma_wdata (dma_wdata),
        .dma_rvalid(dma_rvalid),
        .mem_en    (mem_en),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_din   (mem_din),
        .mem_dout  (mem_dout),
        .mem_rdata (mem_rdata)
    );

    always #5 clk = ~clk;

    // RAM read model: fixed contents at the addresses the bench reads.
    function automatic logic [31:0] ramWord(input logic [11:0] a);
        case (a)
            12'h020: ramWord = 32'h1111_1111;
            12'h030: ramWord = 32'h2222_2222;
            default: ramWord = 32'h0BAD_0000;
        endcase
    endfunction

    always @(posedge clk) begin
        if (mem_en && (mem_we == 4'b0000)) mem_dout <= ramWord(mem_addr);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        totalCnt++;
        assert (obs === exp) passCnt++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        cpu_req = 1'b1; cpu_we = 4'b0000; cpu_addr = 12'h004; cpu_wdata = '0;
        dma_valid = 1'b1; dma_we = 4'b0000; dma_addr = 12'h040; dma_wdata = '0;
        #2;
        // Requests asserted during reset must be ignored.
        check("rst_mem_en", mem_en, 0);
        check("rst_mem_we", mem_we, 0);
        check("rst_dma_ready", dma_ready, 0);
        check("rst_cpu_stall", cpu_stall, 0);
        check("rst_cpu_rvalid", cpu_rvalid, 0);
        check("rst_dma_rvalid", dma_rvalid, 0);
        check("rst_wait_cnt", dut.waitCnt, 0);
        cyc();
        cyc();
        cpu_req = 1'b0; dma_valid = 1'b0;
        rst = 1'b0;
        #1;
        check("idle_mem_en", mem_en, 0);
        check("idle_mem_addr", mem_addr, 0);
        check("idle_mem_din", mem_din, 0);

        // Reset mid-read: DMA read accepted, then rst before data returns is consumed.
        dma_valid = 1'b1; dma_we = 4'b0000; dma_addr = 12'h040;
        #1;
        check("mr_dma_ready", dma_ready, 1);
        check("mr_mem_addr", mem_addr, 12'h040);
        cyc();
        rst = 1'b1;
        dma_valid = 1'b0;
        #1;
        check("mr_rvalid_in_rst", dma_rvalid, 0);
        check("mr_mem_en_in_rst", mem_en, 0);
        cyc();
        rst = 1'b0;
        #1;
        check("mr_rvalid_after", dma_rvalid, 0);
        check("mr_wait_cnt", dut.waitCnt, 0);
        cyc();
        check("mr_rvalid_after2", dma_rvalid, 0);

        // Uncontended DMA write.
        dma_valid = 1'b1; dma_we = 4'b1111; dma_addr = 12'h010; dma_wdata = 32'hDEAD_BEEF;
        #1;
        check("dw_dma_ready", dma_ready, 1);
        check("dw_mem_en", mem_en, 1);
        check("dw_mem_we", mem_we, 4'b1111);
        check("dw_mem_addr", mem_addr, 12'h010);
        check("dw_mem_din", mem_din, 32'hDEAD_BEEF);
        check("dw_cpu_stall", cpu_stall, 0);
        cyc();
        dma_valid = 1'b0; dma_we = 4'b0000;
        check("dw_no_dma_rvalid", dma_rvalid, 0);
        check("dw_no_cpu_rvalid", cpu_rvalid, 0);

        // CPU priority with forced DMA grant after 4 contended cycles.
        cpu_req = 1'b1; cpu_we = 4'b0000; cpu_addr = 12'h004;
        dma_valid = 1'b1; dma_we = 4'b0000; dma_addr = 12'h0AA;
        for (int i = 0; i < 4; i++) begin
            #1;
            check($sformatf("pr_wait_cnt%0d", i), dut.waitCnt, i);
            check($sformatf("pr_stall%0d", i), cpu_stall, 0);
            check($sformatf("pr_dma_ready%0d", i), dma_ready, 0);
            check($sformatf("pr_mem_addr%0d", i), mem_addr, 12'h004);
            cyc();
        end
        #1;
        check("pr_force_dma_ready", dma_ready, 1);
        check("pr_force_stall", cpu_stall, 1);
        check("pr_force_mem_addr", mem_addr, 12'h0AA);
        check("pr_force_cpu_rvalid", cpu_rvalid, 1);
        cyc();
        dma_valid = 1'b0;
        #1;
        check("pr_regrant_stall", cpu_stall, 0);
        check("pr_regrant_mem_addr", mem_addr, 12'h004);
        check("pr_regrant_wait_cnt", dut.waitCnt, 0);
        check("pr_regrant_dma_rvalid", dma_rvalid, 1);
        check("pr_regrant_cpu_rvalid", cpu_rvalid, 0);
        cyc();
        cpu_req = 1'b0;
        cyc();

        // Read steering: CPU read then DMA read, data routed by owner.
        cpu_req = 1'b1; cpu_we = 4'b0000; cpu_addr = 12'h020;
        cyc();
        cpu_req = 1'b0;
        dma_valid = 1'b1; dma_we = 4'b0000; dma_addr = 12'h030;
        #1;
        check("rs_cpu_rvalid", cpu_rvalid, 1);
        check("rs_cpu_rdata", mem_rdata, 32'h1111_1111);
        check("rs_dma_rvalid0", dma_rvalid, 0);
        check("rs_dma_ready", dma_ready, 1);
        cyc();
        dma_valid = 1'b0;
        #1;
        check("rs_dma_rvalid", dma_rvalid, 1);
        check("rs_dma_rdata", mem_rdata, 32'h2222_2222);
        check("rs_cpu_rvalid1", cpu_rvalid, 0);
        cyc();
        check("rs_dma_rvalid_end", dma_rvalid, 0);

        // CPU byte store.
        cpu_req = 1'b1; cpu_we = 4'b0010; cpu_addr = 12'h005; cpu_wdata = 32'h0000_AB00;
        #1;
        check("bs_mem_we", mem_we, 4'b0010);
        check("bs_mem_en", mem_en, 1);
        check("bs_mem_addr", mem_addr, 12'h005);
        check("bs_mem_din", mem_din, 32'h0000_AB00);
        check("bs_cpu_stall", cpu_stall, 0);
        cyc();
        cpu_req = 1'b0; cpu_we = 4'b0000;
        check("bs_no_cpu_rvalid", cpu_rvalid, 0);
        check("bs_no_dma_rvalid", dma_rvalid, 0);

        // dma_valid drops while waiting: counter restarts from 0.
        cpu_req = 1'b1; cpu_addr = 12'h004;
        dma_valid = 1'b1; dma_addr = 12'h0BB;
        cyc();
        cyc();
        dma_valid = 1'b0;
        #1;
        check("dd_wait_cnt_drop", dut.waitCnt, 2);
        check("dd_dma_ready_drop", dma_ready, 0);
        cyc();
        dma_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            check($sformatf("dd_wait_cnt%0d", i), dut.waitCnt, i);
            check($sformatf("dd_dma_ready%0d", i), dma_ready, 0);
            check($sformatf("dd_stall%0d", i), cpu_stall, 0);
            cyc();
        end
        #1;
        check("dd_force_dma_ready", dma_ready, 1);
        check("dd_force_stall", cpu_stall, 1);
        cyc();
        dma_valid = 1'b0; cpu_req = 1'b0;
        #1;
        check("dd_after_wait_cnt", dut.waitCnt, 0);
        cyc();

        $display("%0d/%0d checks passed", passCnt, totalCnt);
        $finish;
    end

endmodule
